tpx3_rx_arbiter_mux: RTL

- N-channel round-robin readout arbiter with burst mode.
- Generalises the two-input arbiter used in the Timepix3 readout core (RX + counter) to CHANNELS RX FIFOs plus one internal counter test source.
- Pops first-word-fall-through channel FIFOs, optionally tags each word with its source index, and drives a registered valid/ready stream into the output BRAM FIFO.
- Keeps per-source word counters for readout.

---
 rtl/tpx3_rx_arbiter_mux.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/tpx3_rx_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module   : tpx3_rx_arbiter_mux
// Function : Round-robin burst arbiter popping CHANNELS FWFT RX FIFOs plus a
//            test counter source into a registered valid/ready output stream.
// Revision : 1.0
// ============================================================================
module tpx3_rx_arbiter_mux #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_BITS    = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                           BUS_CLK,
    input  logic                           BUS_RST,
    input  logic [CHANNELS-1:0]            CH_EMPTY,
    input  logic [CHANNELS*DATA_WIDTH-1:0] CH_DATA,
    output logic [CHANNELS-1:0]            CH_READ,
    input  logic [CHANNELS-1:0]            CH_ENABLE,
    input  logic                           CNT_EN,
    input  logic                           TAG_EN,
    input  logic [7:0]                     BURST_LEN,
    output logic [DATA_WIDTH-1:0]          OUT_DATA,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    input  logic [ID_BITS-1:0]             STAT_SEL,
    input  logic                           STAT_CLR,
    output logic [CNT_WIDTH-1:0]           STAT_CNT
);

    localparam int                 C_NSRC    = CHANNELS + 1;
    localparam logic [ID_BITS-1:0] C_CNT_SRC = ID_BITS'(CHANNELS);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t               r_state;
    logic [ID_BITS-1:0]   r_ptr;
    logic [ID_BITS-1:0]   r_grant;
    logic [7:0]           r_burst_cnt;
    logic [CNT_WIDTH-1:0] r_test_cnt;
    logic [CNT_WIDTH-1:0] r_stat [C_NSRC];

    logic [C_NSRC-1:0]    w_req;
    logic                 w_load;
    logic                 w_found;
    logic                 w_pop;
    logic [ID_BITS-1:0]   w_next;
    logic [ID_BITS-1:0]   w_src;
    logic [7:0]           w_limit;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_cnt_word;
    logic [CNT_WIDTH-1:0]  w_stat_sel;

    assign w_req   = {CNT_EN, CH_ENABLE & ~CH_EMPTY};
    assign w_load  = ~OUT_VALID | OUT_READY;
    assign w_limit = (BURST_LEN == 8'd0) ? 8'd1 : BURST_LEN;

    generate
        if (CNT_WIDTH >= DATA_WIDTH) begin : g_cnt_trunc
            assign w_cnt_word = r_test_cnt[DATA_WIDTH-1:0];
        end else begin : g_cnt_ext
            assign w_cnt_word = {{(DATA_WIDTH-CNT_WIDTH){1'b0}}, r_test_cnt};
        end
    endgenerate

    // First requesting source after the pointer; descending loop so the
    // nearest candidate is the last one assigned.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_next  = '0;
        for (int k = C_NSRC; k >= 1; k--) begin
            idx = (int'(r_ptr) + k) % C_NSRC;
            if (w_req[idx]) begin
                w_found = 1'b1;
                w_next  = ID_BITS'(idx);
            end
        end
    end

    always_comb begin
        w_pop = 1'b0;
        w_src = r_grant;
        if (!BUS_RST) begin
            if (r_state == S_IDLE) begin
                w_src = w_next;
                w_pop = w_found & w_load;
            end else begin
                w_pop = w_load & w_req[r_grant] & (r_burst_cnt < w_limit);
            end
        end
    end

    always_comb begin
        w_head = w_cnt_word;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_src == ID_BITS'(i)) begin
                w_head = CH_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        w_word = w_head;
        if (TAG_EN) begin
            w_word[DATA_WIDTH-1 -: ID_BITS] = w_src;
        end
    end

    always_comb begin
        CH_READ = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            CH_READ[i] = w_pop & (w_src == ID_BITS'(i));
        end
    end

    always_comb begin
        w_stat_sel = '0;
        for (int s = 0; s < C_NSRC; s++) begin
            if (STAT_SEL == ID_BITS'(s)) begin
                w_stat_sel = r_stat[s];
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            r_state     <= S_IDLE;
            r_ptr       <= C_CNT_SRC;
            r_grant     <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state     <= S_BURST;
                        r_grant     <= w_next;
                        r_ptr       <= w_next;
                        r_burst_cnt <= 8'd1;
                    end
                end
                S_BURST: begin
                    // Losing the request or hitting the limit ends the burst
                    // without a pop; re-arbitration happens from IDLE.
                    if (!w_req[r_grant] || (r_burst_cnt >= w_limit)) begin
                        r_state <= S_IDLE;
                    end else if (w_pop) begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            OUT_DATA   <= '0;
            OUT_VALID  <= 1'b0;
            r_test_cnt <= '0;
            STAT_CNT   <= '0;
            for (int s = 0; s < C_NSRC; s++) begin
                r_stat[s] <= '0;
            end
        end else begin
            if (w_pop) begin
                OUT_DATA  <= w_word;
                OUT_VALID <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
            if (w_pop && (w_src == C_CNT_SRC)) begin
                r_test_cnt <= r_test_cnt + CNT_WIDTH'(1);
            end
            for (int s = 0; s < C_NSRC; s++) begin
                if (STAT_CLR) begin
                    r_stat[s] <= '0;
                end else if (w_pop && (w_src == ID_BITS'(s))) begin
                    r_stat[s] <= r_stat[s] + CNT_WIDTH'(1);
                end
            end
            STAT_CNT <= w_stat_sel;
        end
    end

endmodule
`default_nettype wire
